li_rr_arbiter: RTL and testbench

- N-to-1 merge arbiter for latency-insensitive (valid/bp) channels.
- Shares one downstream pipeline stage among NumInputs requesters using a round-robin policy.
- Each accepted token is stored in an internal two-slot output buffer, so outputs are registered and the block sustains full throughput.
- Sits in front of shared units (memory ports, shared function units) that the compiler multiplexes.

---
 rtl/li_rr_arbiter_pkg.sv | 50 +++++
 rtl/li_arb_outbuf.sv | 88 ++++++++
 rtl/li_rr_arbiter.sv | 117 +++++++++++
 tb/tb_li_rr_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/li_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// li_rr_arbiter_pkg
//   Shared definitions for the latency-insensitive round-robin merge arbiter:
//   handshake constants, a transfer helper and the cyclic first-set search
//   used by the grant logic.
// ---------------------------------------------------------------------------
package li_rr_arbiter_pkg;

    // Backpressure encodings on a valid/bp channel.
    localparam logic LI_BP_STALL = 1'b1;
    localparam logic LI_BP_READY = 1'b0;

    // Upper bound on requesters the search function handles.
    localparam int unsigned LI_MAX_INPUTS = 64;
    localparam int unsigned LI_MAX_IDX_W  = $clog2(LI_MAX_INPUTS);

    typedef struct packed {
        logic                    found;
        logic [LI_MAX_IDX_W-1:0] idx;
    } li_first_set_t;

    // A token moves when the sender is valid and the receiver is not stalling.
    function automatic logic li_xfer(input logic valid, input logic bp);
        return valid & ~bp;
    endfunction

    // First set bit of req[num-1:0], scanning start, start+1, ..., wrapping
    // back to start-1. The loop has a constant bound so it unrolls cleanly.
    function automatic li_first_set_t li_cyclic_first_set(
        input logic [LI_MAX_INPUTS-1:0] req,
        input int unsigned              num,
        input int unsigned              start
    );
        li_first_set_t res;
        int unsigned   pos;
        res = '0;
        for (int unsigned k = 0; k < LI_MAX_INPUTS; k++) begin
            if (k < num) begin
                pos = start + k;
                if (pos >= num) pos = pos - num;
                if (!res.found && req[pos]) begin
                    res.found = 1'b1;
                    res.idx   = LI_MAX_IDX_W'(pos);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/li_arb_outbuf.sv
// ---------------------------------------------------------------------------
// li_arb_outbuf
//   Two-slot {data, idx} output buffer. Slot 1 always drives the output;
//   slot 2 catches a token arriving while slot 1 is held, so the upstream
//   side keeps full throughput while the output stays registered.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   d_data/d_idx/d_valid incoming token
//   d_bp                 stall to the producer (both slots full)
//   q_data/q_idx/q_valid head token (slot 1)
//   q_bp                 downstream backpressure
// ---------------------------------------------------------------------------
module li_arb_outbuf
    import li_rr_arbiter_pkg::*;
#(
    parameter int Width    = 8,
    parameter int IdxWidth = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [Width-1:0]    d_data,
    input  logic [IdxWidth-1:0] d_idx,
    input  logic                d_valid,
    output logic                d_bp,
    output logic [Width-1:0]    q_data,
    output logic [IdxWidth-1:0] q_idx,
    output logic                q_valid,
    input  logic                q_bp
);

    logic [Width-1:0]    r_data1, r_data2;
    logic [IdxWidth-1:0] r_idx1, r_idx2;
    logic                r_valid1, r_valid2;
    logic                w_incoming, w_outgoing;

    assign d_bp       = (r_valid1 & r_valid2) ? LI_BP_STALL : LI_BP_READY;
    assign w_incoming = li_xfer(d_valid, d_bp);
    assign w_outgoing = li_xfer(r_valid1, q_bp);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
        end else if (w_incoming && w_outgoing) begin
            // Occupancy unchanged: slot 1 stays full, slot 2 keeps its state.
        end else if (w_outgoing) begin
            r_valid1 <= r_valid2;
            r_valid2 <= 1'b0;
        end else if (w_incoming) begin
            if (!r_valid1) r_valid1 <= 1'b1;
            else           r_valid2 <= 1'b1;
        end
    end

    // NOTE: payload registers carry no reset; they are only observed behind
    // the valid flags, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (w_incoming && w_outgoing) begin
            if (r_valid2) begin
                r_data1 <= r_data2;
                r_idx1  <= r_idx2;
                r_data2 <= d_data;
                r_idx2  <= d_idx;
            end else begin
                r_data1 <= d_data;
                r_idx1  <= d_idx;
            end
        end else if (w_outgoing) begin
            r_data1 <= r_data2;
            r_idx1  <= r_idx2;
        end else if (w_incoming) begin
            if (!r_valid1) begin
                r_data1 <= d_data;
                r_idx1  <= d_idx;
            end else begin
                r_data2 <= d_data;
                r_idx2  <= d_idx;
            end
        end
    end

    assign q_data  = r_data1;
    assign q_idx   = r_idx1;
    assign q_valid = r_valid1;

endmodule

// File: rtl/li_rr_arbiter.sv
// ---------------------------------------------------------------------------
// li_rr_arbiter
//   N-to-1 round-robin merge for latency-insensitive valid/bp channels.
//   Combinational grant from a rotating pointer feeds a two-slot registered
//   output buffer (li_arb_outbuf).
// Ports:
//   clk, resetn   clock, synchronous active-low reset
//   in_data       packed channel data, channel i at [i*Width +: Width]
//   in_valid      per-channel token valid
//   in_last       (LI_ARB_LOCK_EN only) marks the final token of a burst
//   in_bp         per-channel backpressure (all high during reset)
//   out_data      head token data
//   out_idx       head token source channel
//   out_valid     head token valid
//   out_bp        downstream backpressure
// Build option:
//   LI_ARB_LOCK_EN  once a channel's token with in_last=0 is accepted, the
//                   arbiter serves only that channel until its in_last=1
//                   token is accepted.
// ---------------------------------------------------------------------------
module li_rr_arbiter
    import li_rr_arbiter_pkg::*;
#(
    parameter  int NumInputs = 4,
    parameter  int Width     = 8,
    localparam int IdxWidth  = $clog2(NumInputs)
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [NumInputs*Width-1:0] in_data,
    input  logic [NumInputs-1:0]       in_valid,
`ifdef LI_ARB_LOCK_EN
    input  logic [NumInputs-1:0]       in_last,
`endif
    output logic [NumInputs-1:0]       in_bp,
    output logic [Width-1:0]           out_data,
    output logic [IdxWidth-1:0]        out_idx,
    output logic                       out_valid,
    input  logic                       out_bp
);

    logic [NumInputs-1:0]     w_req;
    logic [LI_MAX_INPUTS-1:0] w_req_ext;
    li_first_set_t            w_first;
    logic [NumInputs-1:0]     w_grant;
    logic [IdxWidth-1:0]      w_winner;
    logic [IdxWidth-1:0]      w_next_ptr;
    logic [Width-1:0]         w_win_data;
    logic                     w_buf_bp;
    logic                     w_accept;
    logic                     w_incoming;
    logic [IdxWidth-1:0]      r_ptr;

`ifdef LI_ARB_LOCK_EN
    logic                r_lock;
    logic [IdxWidth-1:0] r_lock_idx;

    // While locked only the owning channel may compete.
    assign w_req = r_lock ? (in_valid & (NumInputs'(1) << r_lock_idx)) : in_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (w_incoming) begin
            r_lock     <= ~in_last[w_winner];
            r_lock_idx <= w_winner;
        end
    end
`else
    assign w_req = in_valid;
`endif

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        w_req_ext                  = '0;
        w_req_ext[NumInputs-1:0]   = w_req;
        w_first  = li_cyclic_first_set(w_req_ext, NumInputs, 32'(r_ptr));
        w_winner = IdxWidth'(w_first.idx);
        w_grant  = '0;
        if (w_first.found) w_grant[w_winner] = 1'b1;
        w_win_data = '0;
        for (int i = 0; i < NumInputs; i++) begin
            if (w_grant[i]) w_win_data = in_data[i*Width +: Width];
        end
    end

    assign w_accept   = ~w_buf_bp;
    assign w_incoming = w_first.found & w_accept;
    assign in_bp      = resetn ? ~(w_grant & {NumInputs{w_accept}}) : '1;

    // Explicit wrap keeps non-power-of-two channel counts in range.
    assign w_next_ptr = (int'(w_winner) == NumInputs - 1) ? '0 : w_winner + IdxWidth'(1);

    always_ff @(posedge clk) begin
        if (!resetn)         r_ptr <= '0;
        else if (w_incoming) r_ptr <= w_next_ptr;
    end

    li_arb_outbuf #(
        .Width    (Width),
        .IdxWidth (IdxWidth)
    ) u_outbuf (
        .clk     (clk),
        .resetn  (resetn),
        .d_data  (w_win_data),
        .d_idx   (w_winner),
        .d_valid (w_first.found),
        .d_bp    (w_buf_bp),
        .q_data  (out_data),
        .q_idx   (out_idx),
        .q_valid (out_valid),
        .q_bp    (out_bp)
    );

endmodule

// File: tb/tb_li_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_li_rr_arbiter
//   Randomized protocol-obeying sources drive the arbiter. A queue-based
//   reference predicts each grant and pushes the expected token; a separate
//   monitor pops and compares every token the DUT delivers.
// ---------------------------------------------------------------------------
module tb_li_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = $clog2(N);

    logic           clk = 1'b0;
    logic           resetn;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_bp;
    logic [W-1:0]   out_data;
    logic [IW-1:0]  out_idx;
    logic           out_valid;
    logic           out_bp;
`ifdef LI_ARB_LOCK_EN
    logic [N-1:0]   in_last;
`endif

    always #5 clk = ~clk;

    li_rr_arbiter #(.NumInputs(N), .Width(W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef LI_ARB_LOCK_EN
        .in_last   (in_last),
`endif
        .in_bp     (in_bp),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_bp    (out_bp)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        int           idx;
    } tok_t;

    tok_t exp_q[$];

    // Source state: a token is held until it transfers.
    logic         src_v[N];
    logic [W-1:0] src_d[N];
    logic         src_last[N];
    logic [N-1:0] xfer;

    // Stimulus configuration.
    logic [N-1:0] cfg_allow;
    int           cfg_pv, cfg_pbp, cfg_plast;
    bit           cfg_fixed, cfg_rst;

    // Reference state: rotating start position, tokens in flight, lock owner.
    int m_ptr, m_cnt, m_lock_idx;
    bit m_lock;

    task automatic drive();
        resetn = !cfg_rst;
        for (int i = 0; i < N; i++) begin
            if (src_v[i] && xfer[i]) src_v[i] = 1'b0;
            if (!src_v[i] && cfg_allow[i] && ($urandom_range(0, 99) < cfg_pv)) begin
                src_v[i]    = 1'b1;
                src_d[i]    = cfg_fixed ? W'(8'hA0 + i) : W'($urandom);
                src_last[i] = ($urandom_range(0, 99) < cfg_plast);
            end
            in_valid[i]       = src_v[i];
            in_data[i*W +: W] = src_d[i];
`ifdef LI_ARB_LOCK_EN
            in_last[i]        = src_last[i];
`endif
        end
        out_bp = ($urandom_range(0, 99) < cfg_pbp);
        xfer   = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] req, exp_bp;
        int           winner;
        bit           accept;
        if (!resetn) begin
            check("reset_in_bp", in_bp, {N{1'b1}});
            exp_q.delete();
            m_cnt  = 0;
            m_ptr  = 0;
            m_lock = 1'b0;
            return;
        end
        check("out_valid", out_valid, (m_cnt > 0));
        req = in_valid;
        if (m_lock) begin
            for (int i = 0; i < N; i++) if (i != m_lock_idx) req[i] = 1'b0;
        end
        winner = -1;
        for (int k = 0; k < N; k++) begin
            if (winner < 0 && req[(m_ptr + k) % N]) winner = (m_ptr + k) % N;
        end
        accept = (m_cnt < 2);
        exp_bp = '1;
        if (winner >= 0 && accept) exp_bp[winner] = 1'b0;
        check("in_bp", in_bp, exp_bp);
        xfer = in_valid & ~in_bp;
        if (m_cnt > 0 && !out_bp) m_cnt--;
        if (winner >= 0 && accept) begin
            exp_q.push_back('{src_d[winner], winner});
            m_ptr = (winner + 1) % N;
`ifdef LI_ARB_LOCK_EN
            m_lock     = !src_last[winner];
            m_lock_idx = winner;
`endif
            m_cnt++;
        end
    endtask

    task automatic phase(input logic [N-1:0] allow, input int pv, input int pbp,
                         input int cycles, input bit fixed, input bit rst);
        cfg_allow = allow;
        cfg_pv    = pv;
        cfg_pbp   = pbp;
        cfg_fixed = fixed;
        cfg_rst   = rst;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            drive();
            @(negedge clk);
            model_step();
        end
    endtask

    // Monitor: every delivered token must match the oldest predicted one.
    initial begin
        tok_t t;
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && out_valid === 1'b1 && out_bp === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_token", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    t = exp_q.pop_front();
                    check("out_data", out_data, t.data);
                    check("out_idx", 32'(out_idx), 32'(t.idx));
                end
            end
        end
    end

    initial begin
        resetn   = 1'b0;
        in_valid = '0;
        in_data  = '0;
        out_bp   = 1'b0;
`ifdef LI_ARB_LOCK_EN
        in_last  = '0;
`endif
        for (int i = 0; i < N; i++) begin
            src_v[i]    = 1'b0;
            src_d[i]    = '0;
            src_last[i] = 1'b1;
        end
        xfer       = '0;
        m_ptr      = 0;
        m_cnt      = 0;
        m_lock     = 1'b0;
        m_lock_idx = 0;
        cfg_plast  = 100;

        phase(4'b0000,   0,   0,   3, 1'b0, 1'b1); // reset
        phase(4'b1111, 100,   0,  16, 1'b1, 1'b0); // fairness, data 0xA0+i
        phase(4'b0100, 100,   0,  10, 1'b0, 1'b0); // channel 2 alone
        phase(4'b1111, 100, 100,   4, 1'b0, 1'b0); // downstream stall
        phase(4'b1111, 100,   0,   8, 1'b0, 1'b0); // release
        phase(4'b1010, 100,   0,  10, 1'b0, 1'b0); // channels 1 and 3, wrap
        phase(4'b1111, 100, 100,   4, 1'b0, 1'b0); // fill both slots
        phase(4'b1111, 100, 100,   1, 1'b0, 1'b1); // reset while full
        phase(4'b1111, 100,   0,   8, 1'b0, 1'b0); // restart from channel 0
        cfg_plast = 40;
        phase(4'b1111,  60,  30, 600, 1'b0, 1'b0); // random traffic
        phase(4'b0101, 100,  20, 100, 1'b0, 1'b0); // random, sparse channels
        cfg_plast = 100;
        phase(4'b0000,   0,   0,  16, 1'b0, 1'b0); // drain
        #1;
        check("drain_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
